// File: rtl/xunit_sha2_round_pkg.sv
// Shared definitions for the SHA-2 compression unit: FSM encoding,
// Sigma rotation amounts for both algorithms and the standard initial hash values.
package xunit_sha2_round_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ROUND = 2'd2,
    ST_FFWD  = 2'd3
  } state_t;

  // SHA-256 big-Sigma rotations
  localparam int S256_R0A = 2;
  localparam int S256_R0B = 13;
  localparam int S256_R0C = 22;
  localparam int S256_R1A = 6;
  localparam int S256_R1B = 11;
  localparam int S256_R1C = 25;

  // SHA-512 big-Sigma rotations
  localparam int S512_R0A = 28;
  localparam int S512_R0B = 34;
  localparam int S512_R0C = 39;
  localparam int S512_R1A = 14;
  localparam int S512_R1B = 18;
  localparam int S512_R1C = 41;

  // Standard initial hash values a..h
  localparam logic [31:0] IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [63:0] IV512 [8] = '{
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

endpackage

// File: rtl/sha2_round_comb.sv
// One combinational SHA-2 compression round; DATA_W picks SHA-256 or SHA-512 Sigmas.
module sha2_round_comb
  import xunit_sha2_round_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  input  logic [DATA_W-1:0] e,
  input  logic [DATA_W-1:0] f,
  input  logic [DATA_W-1:0] g,
  input  logic [DATA_W-1:0] h,
  input  logic [DATA_W-1:0] w,
  input  logic [DATA_W-1:0] k,
  output logic [DATA_W-1:0] a_nxt,
  output logic [DATA_W-1:0] b_nxt,
  output logic [DATA_W-1:0] c_nxt,
  output logic [DATA_W-1:0] d_nxt,
  output logic [DATA_W-1:0] e_nxt,
  output logic [DATA_W-1:0] f_nxt,
  output logic [DATA_W-1:0] g_nxt,
  output logic [DATA_W-1:0] h_nxt
);

  localparam bit IS512 = (DATA_W == 64);
  localparam int R0A = IS512 ? S512_R0A : S256_R0A;
  localparam int R0B = IS512 ? S512_R0B : S256_R0B;
  localparam int R0C = IS512 ? S512_R0C : S256_R0C;
  localparam int R1A = IS512 ? S512_R1A : S256_R1A;
  localparam int R1B = IS512 ? S512_R1B : S256_R1B;
  localparam int R1C = IS512 ? S512_R1C : S256_R1C;

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int n);
    return (x >> n) | (x << (DATA_W - n));
  endfunction

  logic [DATA_W-1:0] bsig0, bsig1, ch, maj, t1, t2;

  // Round function; all sums wrap modulo 2^DATA_W
  always_comb begin
    bsig0 = rotr(a, R0A) ^ rotr(a, R0B) ^ rotr(a, R0C);
    bsig1 = rotr(e, R1A) ^ rotr(e, R1B) ^ rotr(e, R1C);
    ch    = (e & f) ^ (~e & g);
    maj   = (a & b) ^ (a & c) ^ (b & c);
    t1    = h + bsig1 + ch + k + w;
    t2    = bsig0 + maj;
    a_nxt = t1 + t2;
    b_nxt = a;
    c_nxt = b;
    d_nxt = c;
    e_nxt = d + t1;
    f_nxt = e;
    g_nxt = f;
    h_nxt = g;
  end

endmodule

// File: rtl/xunit_sha2_round.sv
// SHA-2 compression unit: optional start delay, programmable number of
// single-cycle rounds fed with W/K from upstream, optional Davies-Meyer feed-forward.
module xunit_sha2_round
  import xunit_sha2_round_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 10,
  parameter int RND_W   = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic               done,
  input  logic [DATA_W-1:0]  in0,
  input  logic [DATA_W-1:0]  in1,
  input  logic [DATA_W-1:0]  in2,
  input  logic [DATA_W-1:0]  in3,
  input  logic [DATA_W-1:0]  in4,
  input  logic [DATA_W-1:0]  in5,
  input  logic [DATA_W-1:0]  in6,
  input  logic [DATA_W-1:0]  in7,
  input  logic [DATA_W-1:0]  in8,
  input  logic [DATA_W-1:0]  in9,
  output logic [DATA_W-1:0]  out0,
  output logic [DATA_W-1:0]  out1,
  output logic [DATA_W-1:0]  out2,
  output logic [DATA_W-1:0]  out3,
  output logic [DATA_W-1:0]  out4,
  output logic [DATA_W-1:0]  out5,
  output logic [DATA_W-1:0]  out6,
  output logic [DATA_W-1:0]  out7,
  input  logic [DELAY_W-1:0] delay0,
  input  logic [RND_W-1:0]   rounds0,
  input  logic               ffwd0
);

  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_width
    $error("xunit_sha2_round: DATA_W must be 32 (SHA-256) or 64 (SHA-512)");
  end

  state_t             state, state_nxt;
  logic [DELAY_W-1:0] dcnt;
  logic [RND_W-1:0]   rcnt, rounds_l;
  logic               ffwd_l;
  logic [DATA_W-1:0]  st [8];   // working variables a..h
  logic [DATA_W-1:0]  hs [8];   // initial state saved for feed-forward
  logic [DATA_W-1:0]  ld [8];
  logic [DATA_W-1:0]  nx [8];

  assign ld[0] = in0;
  assign ld[1] = in1;
  assign ld[2] = in2;
  assign ld[3] = in3;
  assign ld[4] = in4;
  assign ld[5] = in5;
  assign ld[6] = in6;
  assign ld[7] = in7;

  sha2_round_comb #(.DATA_W(DATA_W)) u_round (
    .a(st[0]), .b(st[1]), .c(st[2]), .d(st[3]),
    .e(st[4]), .f(st[5]), .g(st[6]), .h(st[7]),
    .w(in8), .k(in9),
    .a_nxt(nx[0]), .b_nxt(nx[1]), .c_nxt(nx[2]), .d_nxt(nx[3]),
    .e_nxt(nx[4]), .f_nxt(nx[5]), .g_nxt(nx[6]), .h_nxt(nx[7])
  );

  assign done = (state == ST_IDLE);
  assign out0 = st[0];
  assign out1 = st[1];
  assign out2 = st[2];
  assign out3 = st[3];
  assign out4 = st[4];
  assign out5 = st[5];
  assign out6 = st[6];
  assign out7 = st[7];

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; run restarts from WAIT regardless of the current state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_WAIT: begin
        if (dcnt == '0) begin
          if (rounds_l != '0) state_nxt = ST_ROUND;
          else if (ffwd_l)    state_nxt = ST_FFWD;
          else                state_nxt = ST_IDLE;
        end
      end
      ST_ROUND: begin
        if (rcnt == RND_W'(1)) state_nxt = ffwd_l ? ST_FFWD : ST_IDLE;
      end
      ST_FFWD:  state_nxt = ST_IDLE;
      default:  state_nxt = state;
    endcase
    if (run) state_nxt = ST_WAIT;
  end

  // Config latch, counters, working state and the saved initial-state bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt     <= '0;
      rcnt     <= '0;
      rounds_l <= '0;
      ffwd_l   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        st[i] <= '0;
        hs[i] <= '0;
      end
    end else if (run) begin
      dcnt     <= delay0;
      rounds_l <= rounds0;
      ffwd_l   <= ffwd0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (dcnt != '0) begin
            dcnt <= dcnt - 1'b1;
          end else begin
            for (int i = 0; i < 8; i++) begin
              st[i] <= ld[i];
              hs[i] <= ld[i];
            end
            rcnt <= rounds_l;
          end
        end
        ST_ROUND: begin
          for (int i = 0; i < 8; i++) st[i] <= nx[i];
          rcnt <= rcnt - 1'b1;
        end
        ST_FFWD: begin
          for (int i = 0; i < 8; i++) st[i] <= st[i] + hs[i];
        end
        default: ;
      endcase
    end
  end

endmodule
